// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl
//   Sequencer for an external 4-tap FIR datapath. Accepts one unsigned sample
//   per handshake, issues it to the datapath for one cycle, captures the
//   registered accumulator one cycle later, scales it and holds the result
//   until the consumer takes it. Coefficients are written into a shadow bank
//   and copied to the active bank on a commit. The commit then pushes three
//   zero samples through the datapath so that no old samples remain in the
//   delay line.
//
//   Parameter
//     FRAC_SHIFT     right shift applied to fir_acc to form out_data (0..16)
//
//   Optional feature (compile-time macro)
//     FIR_SEQ_CTRL_SAT_EN  defined   : out_data saturates to 16'hFFFF when any
//                                      accumulator bit above the output window
//                                      is set
//                          undefined : out_data is the truncated window (wraps)
//
//   Ports
//     clk, reset                 clock, synchronous active-high reset
//     coeff_wr_en/addr/data      shadow coefficient write (addr 0..3 = tap 1..4)
//     coeff_commit               request to copy shadow to active and flush
//     in_valid/in_ready          input sample handshake
//     in_sample                  input sample
//     fir_enable, fir_sample     datapath step strobe and sample
//     fir_coeff1..fir_coeff4     active coefficients
//     fir_acc                    datapath accumulator, valid a cycle after fir_enable
//     out_valid/out_ready        result handshake
//     out_data                   scaled result
//     busy                       high whenever the sequencer is not idle
module fir_seq_ctrl #(
  parameter int unsigned FRAC_SHIFT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coeff_wr_en,
  input  logic [1:0]  coeff_wr_addr,
  input  logic [15:0] coeff_wr_data,
  input  logic        coeff_commit,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sample,
  output logic        fir_enable,
  output logic [15:0] fir_sample,
  output logic [15:0] fir_coeff1,
  output logic [15:0] fir_coeff2,
  output logic [15:0] fir_coeff3,
  output logic [15:0] fir_coeff4,
  input  logic [31:0] fir_acc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, FLUSH} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       flush_cnt_reg, flush_cnt_next;
  logic             commit_pending_reg, commit_pending_next;
  logic [15:0]      sample_reg, sample_next;
  logic             out_valid_reg, out_valid_next;
  logic [15:0]      out_data_reg, out_data_next;
  logic [3:0][15:0] shadow_reg, shadow_next, active_reg;

  logic             service;
  logic             in_ready_int;
  logic             fir_en_int;
  logic [15:0]      fir_sample_int;

  // Scaling of the captured accumulator
  logic [31:0] acc_shifted;
  logic [15:0] scaled;
  assign acc_shifted = fir_acc >> FRAC_SHIFT;
`ifdef FIR_SEQ_CTRL_SAT_EN
  assign scaled = (|acc_shifted[31:16]) ? 16'hFFFF : acc_shifted[15:0];
`else
  logic acc_hi_unused;
  assign acc_hi_unused = ^acc_shifted[31:16];
  assign scaled        = acc_shifted[15:0];
`endif

  // Shadow bank next value; a write in the same cycle as a commit service is
  // visible to the active bank because the active bank loads shadow_next.
  for (genvar gi = 0; gi < 4; gi++) begin : g_coeff
    assign shadow_next[gi] = (coeff_wr_en && coeff_wr_addr == 2'(gi)) ?
                             coeff_wr_data : shadow_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg <= '0;
      active_reg <= '0;
    end else begin
      shadow_reg <= shadow_next;
      if (service) begin
        active_reg <= shadow_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      flush_cnt_reg      <= '0;
      commit_pending_reg <= 1'b0;
      sample_reg         <= '0;
      out_valid_reg      <= 1'b0;
      out_data_reg       <= '0;
    end else begin
      state_reg          <= state_next;
      flush_cnt_reg      <= flush_cnt_next;
      commit_pending_reg <= commit_pending_next;
      sample_reg         <= sample_next;
      out_valid_reg      <= out_valid_next;
      out_data_reg       <= out_data_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    flush_cnt_next      = flush_cnt_reg;
    sample_next         = sample_reg;
    out_valid_next      = out_valid_reg;
    out_data_next       = out_data_reg;
    // A new commit always lands in the pending flag, even on a service edge,
    // which is what produces a second flush for a commit during FLUSH.
    commit_pending_next = commit_pending_reg | coeff_commit;
    service             = 1'b0;
    in_ready_int        = 1'b0;
    fir_en_int          = 1'b0;
    fir_sample_int      = '0;

    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (commit_pending_reg) begin
          service             = 1'b1;
          commit_pending_next = coeff_commit;
          flush_cnt_next      = '0;
          state_next          = FLUSH;
        end else begin
          // Only accept when the result slot will be free by the capture.
          in_ready_int = !coeff_commit && (!out_valid_reg || out_ready);
          if (in_ready_int && in_valid) begin
            sample_next = in_sample;
            state_next  = ISSUE;
          end
        end
      end
      ISSUE: begin
        fir_en_int     = 1'b1;
        fir_sample_int = sample_reg;
        state_next     = CAPTURE;
      end
      CAPTURE: begin
        out_valid_next = 1'b1;
        out_data_next  = scaled;
        state_next     = IDLE;
      end
      FLUSH: begin
        fir_en_int     = 1'b1;
        flush_cnt_next = flush_cnt_reg + 2'd1;
        if (flush_cnt_reg == 2'd2) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs are forced low during reset so they read as idle
  // from the very first reset cycle.
  assign in_ready   = in_ready_int & ~reset;
  assign fir_enable = fir_en_int & ~reset;
  assign fir_sample = reset ? 16'h0000 : fir_sample_int;
  assign busy       = (state_reg != IDLE) && !reset;
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign fir_coeff1 = active_reg[0];
  assign fir_coeff2 = active_reg[1];
  assign fir_coeff3 = active_reg[2];
  assign fir_coeff4 = active_reg[3];

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: FRAC_SHIFT, default 8, right-shift applied to the 32-bit accumulator to form out_data (legal 0..16).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 coeff_wr_en  in  1  write coeff_wr_data into shadow coefficient coeff_wr_addr.
REQ-006 coeff_wr_addr  in  2  shadow index 0..3, mapping to tap 1..4.
REQ-007 coeff_wr_data  in  16  unsigned coefficient value.
REQ-008 coeff_commit  in  1  single-cycle request to copy shadow bank to active bank and flush taps.
REQ-009 in_valid / in_ready  in / out  1 / 1  input sample handshake; transfer when both high at a rising edge.
REQ-010 in_sample  in  16  unsigned input sample.
REQ-011 fir_enable  out  1  enable to the 4-tap FIR datapath.
REQ-012 fir_sample  out  16  sample presented to the datapath.
REQ-013 fir_coeff1..fir_coeff4  out  16 each  active coefficients.
REQ-014 fir_acc  in  32  registered datapath accumulator, valid one cycle after fir_enable.
REQ-015 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-016 out_data  out  16  scaled result.
REQ-017 busy  out  1  high whenever state != IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, CAPTURE and FLUSH.
REQ-019 in_ready SHALL be high only when state=IDLE, no commit is pending or arriving, and (!out_valid or out_ready).
REQ-020 On accept at edge T, the sample SHALL be latched and the FSM SHALL enter ISSUE; in the ISSUE cycle, fir_enable=1 and fir_sample=latched value.
REQ-021 In CAPTURE (cycle T+2), fir_acc SHALL be scaled and registered; out_valid SHALL rise at T+3 and the FSM SHALL return to IDLE; latency is 3 cycles and throughput is 1 sample per 3 cycles.
REQ-022 Scaling: out_data = fir_acc[FRAC_SHIFT+15:FRAC_SHIFT]; bits above that range are handled per REQ-033/034.
REQ-023 out_valid/out_data SHALL hold stable until out_ready is high at an edge; simultaneous drain and a new accept SHALL both occur.
REQ-024 fir_enable SHALL be 0 in IDLE and CAPTURE; fir_sample SHALL be 0 whenever fir_enable=0.
REQ-025 Coefficient writes SHALL update only the shadow bank, at any time including while busy.
REQ-026 coeff_commit SHALL set a pending flag; the commit is serviced in IDLE with priority over in_valid, and a commit arriving during ISSUE, CAPTURE or FLUSH SHALL be held pending.
REQ-027 On service, the active bank SHALL take the shadow bank (including a coeff_wr_en in the same cycle as the service edge), the pending flag SHALL clear, and the FSM SHALL enter FLUSH.
REQ-028 FLUSH SHALL drive exactly 3 consecutive cycles of fir_enable=1 with fir_sample=0, discard the results, leave out_valid untouched, and then return to IDLE.
REQ-029 A commit arriving during FLUSH SHALL cause a second full flush after the current one completes.

Reset
REQ-030 While reset is high: state=IDLE; shadow and active coefficients, latched sample, pending flag, out_data = 0; out_valid, fir_enable, busy = 0; in_ready = 0.
REQ-031 Reset mid-operation SHALL discard in-flight samples, held results and pending commits without emitting any out_valid.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-033 With FIR_SEQ_CTRL_SAT_EN defined, if any fir_acc bit above FRAC_SHIFT+15 is 1, out_data SHALL be 16'hFFFF.
REQ-034 Without FIR_SEQ_CTRL_SAT_EN, out_data SHALL be the plain truncated slice (wraps).

Verification
REQ-035 Identity: FRAC_SHIFT=0, coeffs {1,0,0,0} committed, sample 5 accepted at T -> out_valid at T+3, out_data=5.
REQ-036 Moving sum: coeffs {1,1,1,1}, FRAC_SHIFT=0, samples 1,2,3,4 -> outputs 1,3,6,10 in order.
REQ-037 Backpressure: out_ready=0 for 10 cycles after a result -> out_data stable, in_ready=0; out_ready=1 -> drain and in_ready=1 in the same cycle.
REQ-038 Commit flush: coeffs {1,1,1,1}, samples 9,9,9, commit, then sample 7 -> busy high for 3 flush cycles with fir_enable=1 and fir_sample=0; next output is 7.
REQ-039 Saturation: FRAC_SHIFT=0, coeffs {16'h0100,0,0,0}, sample 16'h0100 -> out_data=16'hFFFF with macro, 16'h0000 without.
REQ-040 Reset in CAPTURE -> no out_valid, all outputs 0, in_ready=1 in the first cycle after reset deasserts.
